uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver with oversampled bit timing, optional parity and error flags.
// rx is synchronized and then sampled only on sample_en ticks, mid-bit.
// A completed frame loads rx_data and the status flags together.
module uart_rx #(
    parameter int   DATA_WIDTH  = 8,
    parameter logic PARITY_EN   = 1'b1,
    parameter logic PARITY_TYPE = 1'b0,
    parameter int   OVERSAMPLE  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_en,
    input  logic                  rx,
    input  logic                  rd_ack,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  rx_busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;
    localparam int IDX_W  = $clog2(DATA_WIDTH);

    localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  frame_done;
    logic                  rx_meta, rx_s, rx_prev;
    logic                  exp_par;

    // Two-flop synchronizer; resets to the idle (high) line level.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Line level at the previous sample tick, for start-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         rx_prev <= 1'b1;
        else if (sample_en) rx_prev <= rx_s;
    end

    // Next-state, counter and shift-register logic; only advances on sample ticks.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        frame_done = 1'b0;
        if (sample_en) begin
            case (state_q)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == TICK_END) begin
                        tick_d = '0;
                        shift_d[bit_q[IDX_W-1:0]] = rx_s;
                        if (bit_q == BIT_LAST) state_d = PARITY_EN ? PARITY : STOP;
                        else                   bit_d   = bit_q + 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick_q == TICK_END) begin
                        tick_d  = '0;
                        par_d   = rx_s;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == TICK_END) begin
                        tick_d     = '0;
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM, counters and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            // NOTE: the shift register is a handful of flops, not a RAM, so resetting it is cheap and keeps it X-free.
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    assign exp_par = PARITY_TYPE ? ~^shift_q : ^shift_q;

    // Output word, status flags and handshake; new data beats a same-edge rd_ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (frame_done) begin
                rx_data     <= shift_q;
                parity_err  <= PARITY_EN && (par_q != exp_par);
                frame_err   <= ~rx_s;
                data_valid  <= 1'b1;
                overrun_err <= data_valid;
            end else if (rd_ack) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: an even-parity and an odd-parity receiver
// share one serial line; a scoreboard checks every completed frame.
module tb_uart_rx;

    localparam int OS       = 16;
    localparam int BIT_CLKS = 2 * OS;   // sample_en pulses every other clock

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_en;
    logic       rx;
    logic       rd_ack;
    logic [7:0] rx_data,   o_rx_data;
    logic       data_valid, o_data_valid;
    logic       parity_err, o_parity_err;
    logic       frame_err,  o_frame_err;
    logic       overrun_err, o_overrun_err;
    logic       rx_busy,    o_rx_busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       sbit;
        logic       perr;
        logic       perr_odd;
        logic       ferr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       perr_odd;
        logic       ferr;
        logic       ov;
    } exp_t;

    exp_t sb[$];
    int   ov_seen = 0;

    uart_rx #(.DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_TYPE(1'b0), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .rx(rx), .rd_ack(rd_ack),
        .rx_data(rx_data), .data_valid(data_valid), .parity_err(parity_err),
        .frame_err(frame_err), .overrun_err(overrun_err), .rx_busy(rx_busy)
    );

    uart_rx #(.DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_TYPE(1'b1), .OVERSAMPLE(OS)) dut_odd (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .rx(rx), .rd_ack(rd_ack),
        .rx_data(o_rx_data), .data_valid(o_data_valid), .parity_err(o_parity_err),
        .frame_err(o_frame_err), .overrun_err(o_overrun_err), .rx_busy(o_rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        sample_en = 1'b0;
        forever begin
            @(negedge clk);
            sample_en = ~sample_en;
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard: a completion is a data_valid rise or an overrun pulse.
    initial begin
        logic dv_prev;
        exp_t e;
        dv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && ((data_valid && !dv_prev) || overrun_err)) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got frame 0x%0h with nothing expected at %0t", rx_data, $time);
                end else begin
                    e = sb.pop_front();
                    check("sb_data",     rx_data,      e.data);
                    check("sb_perr",     parity_err,   e.perr);
                    check("sb_ferr",     frame_err,    e.ferr);
                    check("sb_overrun",  overrun_err,  e.ov);
                    check("sb_perr_odd", o_parity_err, e.perr_odd);
                    check("sb_data_odd", o_rx_data,    e.data);
                end
            end
            if (overrun_err) ov_seen++;
            dv_prev = data_valid;
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(pb);
        drive_bit(sb_bit);
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic peo, input logic fe, input logic ov);
        exp_t e;
        e.data = d; e.perr = pe; e.perr_odd = peo; e.ferr = fe; e.ov = ov;
        sb.push_back(e);
    endtask

    task automatic ack(input string name);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        check(name, data_valid, 1'b0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n  = 1'b0;
        rx     = 1'b1;
        rd_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_data",    rx_data,     8'h00);
        check("rst_valid",   data_valid,  1'b0);
        check("rst_perr",    parity_err,  1'b0);
        check("rst_ferr",    frame_err,   1'b0);
        check("rst_overrun", overrun_err, 1'b0);
        check("rst_busy",    rx_busy,     1'b0);
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);

        // Table-driven frames, each acknowledged before the next.
        for (int i = 0; i < 7; i++) begin
            push(vecs[i].data, vecs[i].perr, vecs[i].perr_odd, ~vecs[i].sbit, 1'b0);
            send_frame(vecs[i].data, vecs[i].pbit, vecs[i].sbit);
            drive_bit(1'b1);
            drive_bit(1'b1);
            check("tbl_valid", data_valid, 1'b1);
            check("tbl_busy",  rx_busy,    1'b0);
            ack("tbl_ack");
        end

        // Short low glitch: must fall back to idle with no output.
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        check("glitch_busy_hi", rx_busy, 1'b1);
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("glitch_busy_lo", rx_busy,    1'b0);
        check("glitch_valid",   data_valid, 1'b0);

        // Stop bit low, line held low 20 bit times: no retrigger.
        push(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive_bit(1'b0);
            check("hold_low_busy", rx_busy, 1'b0);
        end
        check("ferr_valid", data_valid, 1'b1);
        ack("ferr_ack");
        drive_bit(1'b1);
        drive_bit(1'b1);
        push(8'h12, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        ack("after_low_ack");

        // Back-to-back frames without acknowledge: one overrun.
        push(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        push(8'h02, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'h02, 1'b1, 1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("b2b_ov_count", ov_seen, 1);
        check("b2b_data",     rx_data, 8'h02);
        check("b2b_valid",    data_valid, 1'b1);
        ack("b2b_ack");

        // Leave a word unread, then reset in the middle of data bit 3.
        push(8'h7E, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        check("pre_rst_busy", rx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data",  rx_data,     8'h00);
        check("mid_rst_valid", data_valid,  1'b0);
        check("mid_rst_perr",  parity_err,  1'b0);
        check("mid_rst_ferr",  frame_err,   1'b0);
        check("mid_rst_busy",  rx_busy,     1'b0);
        check("mid_rst_obusy", o_rx_busy,   1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("post_rst_idle", rx_busy, 1'b0);
        push(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("post_rst_data", rx_data, 8'hFF);
        ack("post_rst_ack");

        repeat (BIT_CLKS) @(negedge clk);
        check("sb_empty",    sb.size(), 0);
        check("ov_total",    ov_seen,   1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
